// File: rtl/i2c_master_if.sv
// rtl/i2c_master_if.sv - host-side request/status bundle for i2c_master
interface i2c_master_if;
  logic       start;
  logic       rw_bit;
  logic [6:0] slave_addr;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;
  logic       ack_error;

  // The I2C master consumes requests and produces status
  modport master (
    input  start, rw_bit, slave_addr, tx_data,
    output rx_data, busy, done, ack_error
  );

  // Host logic issues requests and observes status
  modport slave (
    output start, rw_bit, slave_addr, tx_data,
    input  rx_data, busy, done, ack_error
  );
endinterface

// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - single-byte 7-bit-address I2C master with debug taps
module i2c_master #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int I2C_FREQ = 100_000
) (
  input  logic         clk,
  input  logic         rst_n,          // active-high synchronous reset
  i2c_master_if.master host,
  inout  wire          sda,
  output logic         scl,
  output logic         debug_busy,
  output logic         debug_ack,
  output logic [4:0]   debug_state,
  output logic         debug_scl,
  output logic         debug_sda_out,
  output logic         debug_sda_oe
);

  localparam int QUARTER = CLK_FREQ / (4 * I2C_FREQ);
  localparam int CW      = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(QUARTER - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [4:0] {
    IDLE      = 5'd0,
    START     = 5'd1,
    ADDR      = 5'd2,
    ADDR_ACK  = 5'd3,
    WRITE     = 5'd4,
    WRITE_ACK = 5'd5,
    READ      = 5'd6,
    READ_NACK = 5'd7,
    STOP      = 5'd8,
    DONE      = 5'd9
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          rw_q, rw_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          ack_err_q, ack_err_d;
  logic          ack_q, ack_d;
  logic          scl_q, scl_d;
  logic          sda_oe_q, sda_oe_d;
  logic          sda_out_q, sda_out_d;

  logic q_last;
  logic slot_end;
  logic sample_pt;
  logic sda_upd;
  logic sda_in;

  // Open-drain SDA: only ever pull low, otherwise let the pull-up win
  assign sda    = (sda_oe_q && !sda_out_q) ? 1'b0 : 1'bz;
  assign sda_in = sda;

  // Timing strobes within a 4-quarter bus slot
  assign q_last    = (cnt_q == CNT_MAX);
  assign slot_end  = q_last && (qtr_q == 2'd3);
  assign sample_pt = q_last && (qtr_q == 2'd2);
  // SDA moves one cycle after SCL has been registered low, so the two
  // never change on the same edge
  assign sda_upd   = (qtr_q == 2'd0) && (cnt_q == CNT_ONE);

  // Quarter-period counter; parked at zero while no slot is running
  always_comb begin
    cnt_d = cnt_q;
    qtr_d = qtr_q;
    if (state_q == IDLE || state_q == DONE) begin
      cnt_d = '0;
      qtr_d = 2'd0;
    end else if (q_last) begin
      cnt_d = '0;
      qtr_d = qtr_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Quarter-period counter registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q <= '0;
      qtr_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      qtr_q <= qtr_d;
    end
  end

  // Next-state, datapath and bus-drive decisions
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    tx_d       = tx_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    ack_err_d  = ack_err_q;
    ack_d      = ack_q;
    scl_d      = 1'b1;
    sda_oe_d   = sda_oe_q;
    sda_out_d  = sda_out_q;

    case (state_q)
      IDLE: begin
        sda_oe_d  = 1'b0;
        sda_out_d = 1'b1;
        if (host.start) begin
          shift_d   = {host.slave_addr, host.rw_bit};
          rw_d      = host.rw_bit;
          tx_d      = host.tx_data;
          ack_err_d = 1'b0;
          state_d   = START;
        end
      end

      START: begin
        // SDA falls in q2 with SCL high, then SCL drops in q3
        scl_d = (qtr_q != 2'd3);
        if (qtr_q < 2'd2) begin
          sda_oe_d  = 1'b0;
          sda_out_d = 1'b1;
        end else if (qtr_q == 2'd2) begin
          sda_oe_d  = 1'b1;
          sda_out_d = 1'b0;
        end
        if (slot_end) begin
          state_d = ADDR;
          bit_d   = 3'd7;
        end
      end

      ADDR, WRITE: begin
        scl_d = qtr_q[1];
        if (sda_upd) begin
          sda_oe_d  = 1'b1;
          sda_out_d = shift_q[bit_q];
        end
        if (slot_end) begin
          if (bit_q == 3'd0) begin
            state_d = (state_q == ADDR) ? ADDR_ACK : WRITE_ACK;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end

      ADDR_ACK, WRITE_ACK: begin
        scl_d = qtr_q[1];
        if (sda_upd) begin
          sda_oe_d  = 1'b0;
          sda_out_d = 1'b1;
        end
        if (sample_pt) begin
          ack_d = ~sda_in;
          if (sda_in) begin
            ack_err_d = 1'b1;
          end
        end
        if (slot_end) begin
          if (state_q == WRITE_ACK || !ack_q) begin
            state_d = STOP;
          end else if (rw_q) begin
            state_d = READ;
            bit_d   = 3'd7;
          end else begin
            state_d = WRITE;
            bit_d   = 3'd7;
            shift_d = tx_q;
          end
        end
      end

      READ: begin
        scl_d = qtr_q[1];
        if (sda_upd) begin
          sda_oe_d  = 1'b0;
          sda_out_d = 1'b1;
        end
        if (sample_pt) begin
          rx_shift_d = {rx_shift_q[6:0], sda_in};
        end
        if (slot_end) begin
          if (bit_q == 3'd0) begin
            state_d = READ_NACK;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end

      READ_NACK: begin
        // Single-byte read: leave SDA high so the slave sees a NACK
        scl_d = qtr_q[1];
        if (sda_upd) begin
          sda_oe_d  = 1'b0;
          sda_out_d = 1'b1;
        end
        if (slot_end) begin
          rx_data_d = rx_shift_q;
          state_d   = STOP;
        end
      end

      STOP: begin
        // Pull SDA low under a low SCL, raise SCL, then release SDA
        scl_d = (qtr_q != 2'd0);
        if (sda_upd) begin
          sda_oe_d  = 1'b1;
          sda_out_d = 1'b0;
        end else if (qtr_q == 2'd2) begin
          sda_oe_d  = 1'b0;
          sda_out_d = 1'b1;
        end
        if (slot_end) begin
          state_d = DONE;
        end
      end

      DONE: begin
        sda_oe_d  = 1'b0;
        sda_out_d = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        sda_oe_d  = 1'b0;
        sda_out_d = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  // FSM and datapath registers; reset aborts immediately without a STOP
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      rw_q       <= 1'b0;
      tx_q       <= 8'd0;
      rx_shift_q <= 8'd0;
      rx_data_q  <= 8'd0;
      ack_err_q  <= 1'b0;
      ack_q      <= 1'b0;
      scl_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
      sda_out_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      tx_q       <= tx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      ack_err_q  <= ack_err_d;
      ack_q      <= ack_d;
      scl_q      <= scl_d;
      sda_oe_q   <= sda_oe_d;
      sda_out_q  <= sda_out_d;
    end
  end

  assign scl            = scl_q;
  assign host.rx_data   = rx_data_q;
  assign host.busy      = (state_q != IDLE);
  assign host.done      = (state_q == DONE);
  assign host.ack_error = ack_err_q;

  assign debug_busy    = (state_q != IDLE);
  assign debug_ack     = ack_q;
  assign debug_state   = state_q;
  assign debug_scl     = scl_q;
  assign debug_sda_out = sda_out_q;
  assign debug_sda_oe  = sda_oe_q;

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - directed self-checking bench for i2c_master
module tb_i2c_master;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  i2c_master_if host();

  wire        sda;
  logic       scl;
  logic       debug_busy, debug_ack, debug_scl, debug_sda_out, debug_sda_oe;
  logic [4:0] debug_state;
  logic       slave_low = 1'b0;

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  i2c_master dut (
    .clk(clk), .rst_n(rst_n), .host(host), .sda(sda), .scl(scl),
    .debug_busy(debug_busy), .debug_ack(debug_ack), .debug_state(debug_state),
    .debug_scl(debug_scl), .debug_sda_out(debug_sda_out), .debug_sda_oe(debug_sda_oe)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;
  int dur = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural slave at address 0x55, edge-detected on the falling clk
  localparam logic [6:0] SLV = 7'h55;
  logic       pscl = 1'b1, psda = 1'b1;
  int         start_cnt = 0, stop_cnt = 0, bitn = 0, byte_idx = 0, data_bits = 0, nrise = 0;
  int         rise_t0 = 0, rise_t1 = 0;
  logic       in_ack = 1'b0, active = 1'b0, acked = 1'b0, rd = 1'b0, ninth = 1'b0;
  logic       nack_data = 1'b0;
  logic [7:0] shift = 8'd0, addr_seen = 8'd0, data_seen = 8'd0, rd_byte = 8'd0;

  always @(negedge clk) begin
    if (pscl === 1'b1 && scl === 1'b1 && psda === 1'b1 && sda === 1'b0) begin
      start_cnt++; bitn = 0; byte_idx = 0; in_ack = 0; slave_low = 0;
      active = 1; data_bits = 0; nrise = 0;
    end else if (pscl === 1'b1 && scl === 1'b1 && psda === 1'b0 && sda === 1'b1) begin
      stop_cnt++; active = 0; slave_low = 0;
    end else if (pscl === 1'b0 && scl === 1'b1 && active) begin
      if (nrise == 0) rise_t0 = cyc;
      if (nrise == 1) rise_t1 = cyc;
      nrise++;
      if (bitn < 8) begin
        shift = {shift[6:0], sda};
        bitn++;
        if (byte_idx == 1) data_bits++;
      end else begin
        ninth = sda;
      end
    end else if (pscl === 1'b1 && scl === 1'b0 && active) begin
      if (bitn == 8 && !in_ack) begin
        in_ack = 1;
        if (byte_idx == 0) begin
          addr_seen = shift; acked = (shift[7:1] == SLV); rd = shift[0]; slave_low = acked;
        end else if (!rd) begin
          data_seen = shift; slave_low = !nack_data;
        end else begin
          slave_low = 0;
        end
      end else if (bitn == 8 && in_ack) begin
        in_ack = 0; bitn = 0; slave_low = 0;
        if (byte_idx == 0 && acked && rd) slave_low = !rd_byte[7];
        if (byte_idx == 0 && !acked) active = 0;
        byte_idx++;
      end else if (byte_idx == 1 && rd && bitn > 0 && bitn < 8) begin
        slave_low = !rd_byte[7 - bitn];
      end
    end
    pscl = scl;
    psda = sda;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_txn(input logic [6:0] a, input logic r, input logic [7:0] d);
    @(negedge clk);
    host.slave_addr = a; host.rw_bit = r; host.tx_data = d; host.start = 1'b1;
    @(negedge clk);
    host.start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (host.done !== 1'b1 && n < 40000) begin
      @(negedge clk);
      n++;
    end
    dur = cyc - t0;
    check("done_seen", {31'd0, host.done}, 32'd1);
    check("busy_at_done", {31'd0, host.busy}, 32'd1);
    @(negedge clk);
    check("done_one_cycle", {31'd0, host.done}, 32'd0);
    check("busy_after_done", {31'd0, host.busy}, 32'd0);
  endtask

  int s0, p0, extra;

  initial begin
    host.start = 1'b0; host.rw_bit = 1'b0; host.slave_addr = 7'd0; host.tx_data = 8'd0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_scl", {31'd0, scl}, 32'd1);
    check("rst_sda_oe", {31'd0, debug_sda_oe}, 32'd0);
    check("rst_sda_out", {31'd0, debug_sda_out}, 32'd1);
    check("rst_sda", {31'd0, sda}, 32'd1);
    check("rst_busy", {31'd0, host.busy}, 32'd0);
    check("rst_done", {31'd0, host.done}, 32'd0);
    check("rst_ack_error", {31'd0, host.ack_error}, 32'd0);
    check("rst_rx_data", {24'd0, host.rx_data}, 32'd0);
    check("rst_debug_ack", {31'd0, debug_ack}, 32'd0);
    check("rst_state", {27'd0, debug_state}, 32'd0);

    // Write 0x55 / 0xA5 to an ACKing slave
    s0 = start_cnt; p0 = stop_cnt;
    start_txn(7'h55, 1'b0, 8'hA5);
    check("t1_busy", {31'd0, host.busy}, 32'd1);
    check("t1_debug_busy", {31'd0, debug_busy}, 32'd1);
    wait_done();
    check("t1_addr_byte", {24'd0, addr_seen}, 32'hAA);
    check("t1_data_byte", {24'd0, data_seen}, 32'hA5);
    check("t1_ack_error", {31'd0, host.ack_error}, 32'd0);
    check("t1_debug_ack", {31'd0, debug_ack}, 32'd1);
    check("t1_scl_period", rise_t1 - rise_t0, 32'd1000);
    check("t1_duration", {31'd0, (dur >= 19998 && dur <= 20002)}, 32'd1);
    check("t1_one_start", start_cnt - s0, 32'd1);
    check("t1_one_stop", stop_cnt - p0, 32'd1);

    // Back-to-back write after 50 us idle
    repeat (5000) @(negedge clk);
    s0 = start_cnt; p0 = stop_cnt;
    start_txn(7'h55, 1'b0, 8'h3C);
    wait_done();
    check("t2_data_byte", {24'd0, data_seen}, 32'h3C);
    check("t2_ack_error", {31'd0, host.ack_error}, 32'd0);
    check("t2_one_start", start_cnt - s0, 32'd1);
    check("t2_one_stop", stop_cnt - p0, 32'd1);

    // Address NACK
    s0 = start_cnt; p0 = stop_cnt;
    start_txn(7'h22, 1'b0, 8'h77);
    wait_done();
    check("t3_addr_byte", {24'd0, addr_seen}, 32'h44);
    check("t3_ack_error", {31'd0, host.ack_error}, 32'd1);
    check("t3_debug_ack", {31'd0, debug_ack}, 32'd0);
    check("t3_no_data_bits", data_bits, 32'd0);
    check("t3_one_stop", stop_cnt - p0, 32'd1);
    check("t3_duration", {31'd0, (dur >= 10998 && dur <= 11002)}, 32'd1);
    check("t3_sticky", {31'd0, host.ack_error}, 32'd1);

    // Read 0x55, slave returns 0xC3; ack_error must clear on acceptance
    rd_byte = 8'hC3;
    start_txn(7'h55, 1'b1, 8'h00);
    check("t4_ack_error_cleared", {31'd0, host.ack_error}, 32'd0);
    wait_done();
    check("t4_addr_byte", {24'd0, addr_seen}, 32'hAB);
    check("t4_master_nack", {31'd0, ninth}, 32'd1);
    check("t4_rx_data", {24'd0, host.rx_data}, 32'hC3);
    check("t4_ack_error", {31'd0, host.ack_error}, 32'd0);
    check("t4_duration", {31'd0, (dur >= 19998 && dur <= 20002)}, 32'd1);

    // start while busy is ignored
    start_txn(7'h55, 1'b0, 8'h96);
    repeat (3000) @(negedge clk);
    host.slave_addr = 7'h22; host.rw_bit = 1'b1; host.tx_data = 8'h00; host.start = 1'b1;
    @(negedge clk);
    host.start = 1'b0;
    wait_done();
    check("t5_addr_byte", {24'd0, addr_seen}, 32'hAA);
    check("t5_data_byte", {24'd0, data_seen}, 32'h96);
    check("t5_ack_error", {31'd0, host.ack_error}, 32'd0);
    check("t5_rx_data_held", {24'd0, host.rx_data}, 32'hC3);
    check("t5_duration", {31'd0, (dur >= 19998 && dur <= 20002)}, 32'd1);

    // Data NACK
    nack_data = 1'b1;
    p0 = stop_cnt;
    start_txn(7'h55, 1'b0, 8'h81);
    wait_done();
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (host.done === 1'b1) extra++;
    end
    check("t6_data_byte", {24'd0, data_seen}, 32'h81);
    check("t6_ack_error", {31'd0, host.ack_error}, 32'd1);
    check("t6_debug_ack", {31'd0, debug_ack}, 32'd0);
    check("t6_one_stop", stop_cnt - p0, 32'd1);
    check("t6_single_done", extra, 32'd0);
    nack_data = 1'b0;

    // Reset held mid-ADDR
    start_txn(7'h55, 1'b0, 8'h5A);
    repeat (2500) @(negedge clk);
    check("t7_in_addr", {27'd0, debug_state}, 32'd2);
    rst_n = 1'b1;
    @(negedge clk);
    check("t7_scl", {31'd0, scl}, 32'd1);
    check("t7_sda_oe", {31'd0, debug_sda_oe}, 32'd0);
    check("t7_sda", {31'd0, sda}, 32'd1);
    check("t7_busy", {31'd0, host.busy}, 32'd0);
    check("t7_state", {27'd0, debug_state}, 32'd0);
    check("t7_rx_data", {24'd0, host.rx_data}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("t7_stay_idle", {27'd0, debug_state}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
